// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, types and stage/level mapping for the pipelined Kogge-Stone adder
package cla_pkg;
    localparam int WIDTH = 16;
    localparam int PREFIX_LEVELS = $clog2(WIDTH);
    localparam int LATENCY = 2 + (PREFIX_LEVELS + 1) / 2;
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;
    typedef logic [WIDTH:0] sum_t;
    function automatic int stage_level(input int k);
        return (2 * k - 1 < PREFIX_LEVELS) ? 2 * k - 1 : PREFIX_LEVELS - 1;
    endfunction
endpackage

// File: rtl/cla_prefix_cell.sv
// cla_prefix_cell: Kogge-Stone black cell (g_hi, p_hi, g_lo, p_lo -> g_out = g_hi | p_hi & g_lo, p_out = p_hi & p_lo)
module cla_prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);
    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;
endmodule

// File: rtl/cla_pipelined_16.sv
// cla_pipelined_16: 4-stage Kogge-Stone adder, ports clk, rst (async high), a, b -> out = a + b (WIDTH+1 bits, registered); `CLA_VALID_EN adds in_valid -> out_valid
module cla_pipelined_16
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CLA_VALID_EN
    input  logic             in_valid,
    output logic             out_valid,
`endif
    output logic [WIDTH:0]   out
);
    localparam int STG = (PREFIX_LEVELS + 1) / 2;
    gp_t gp0;
    sum_t sum;
    logic [STG:0][WIDTH-1:0] rg;
    logic [STG-1:0][WIDTH-1:0] rp;
    logic [STG:1][WIDTH-1:0] rporig;
    logic [PREFIX_LEVELS-1:0][WIDTH-1:0] gi, pi, go, po;
    logic unused_p;
    assign gp0 = '{g: a & b, p: a ^ b};
    genvar l, i;
    generate
        for (l = 0; l < PREFIX_LEVELS; l++) begin : g_lvl
            if (l % 2 == 0) begin : g_reg_in
                assign gi[l] = rg[l/2];
                assign pi[l] = rp[l/2];
            end else begin : g_comb_in
                assign gi[l] = go[l-1];
                assign pi[l] = po[l-1];
            end
            for (i = 0; i < WIDTH; i++) begin : g_bit
                if (i < (1 << l)) begin : g_pass
                    assign go[l][i] = gi[l][i];
                    assign po[l][i] = pi[l][i];
                end else begin : g_cell
                    cla_prefix_cell u_cell (
                        .g_hi (gi[l][i]),
                        .p_hi (pi[l][i]),
                        .g_lo (gi[l][i-(1<<l)]),
                        .p_lo (pi[l][i-(1<<l)]),
                        .g_out(go[l][i]),
                        .p_out(po[l][i])
                    );
                end
            end
        end
    endgenerate
    assign unused_p = ^po[PREFIX_LEVELS-1];
    assign sum = {rg[STG][WIDTH-1], rporig[STG] ^ {rg[STG][WIDTH-2:0], 1'b0}};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rg     <= '0;
            rp     <= '0;
            rporig <= '0;
            out    <= '0;
        end else begin
            rg[0] <= gp0.g;
            rp[0] <= gp0.p;
            for (int k = 1; k <= STG; k++) rg[k] <= go[stage_level(k)];
            for (int k = 1; k < STG; k++) rp[k] <= po[stage_level(k)];
            rporig[1] <= rp[0];
            for (int k = 2; k <= STG; k++) rporig[k] <= rporig[k-1];
            out <= sum;
        end
    end
`ifdef CLA_VALID_EN
    logic [LATENCY-1:0] vsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vsr <= '0;
        else vsr <= {vsr[LATENCY-2:0], in_valid};
    end
    assign out_valid = vsr[LATENCY-1];
`endif
endmodule

// File: tb/tb_cla_pipelined_16.sv
// tb_cla_pipelined_16: directed and random scoreboard bench for cla_pipelined_16
module tb_cla_pipelined_16;
    import cla_pkg::*;
    typedef struct packed {
        logic [WIDTH:0] s;
        logic           v;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH:0] out;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
`ifdef CLA_VALID_EN
    logic in_valid = 1'b0;
    logic out_valid;
`endif
    always #5 clk = ~clk;
    cla_pipelined_16 dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
`ifdef CLA_VALID_EN
        .in_valid(in_valid),
        .out_valid(out_valid),
`endif
        .out(out)
    );
    task automatic chk(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic v);
        exp_t e;
        a = x;
        b = y;
`ifdef CLA_VALID_EN
        in_valid = v;
`endif
        @(posedge clk);
        #1;
        if (!rst) q.push_back('{s: {1'b0, x} + {1'b0, y}, v: v});
        e = (q.size() == LATENCY) ? q.pop_front() : '0;
        chk(tag, out, e.s);
`ifdef CLA_VALID_EN
        chk({tag, "_valid"}, {{WIDTH{1'b0}}, out_valid}, {{WIDTH{1'b0}}, e.v});
`endif
    endtask
    initial begin
        #1;
        chk("rst_t0", out, '0);
        for (int n = 0; n < 3; n++) step("rst_hold", 16'hFFFF, 16'hFFFF, 1'b1);
        rst = 1'b0;
        step("max", 16'hFFFF, 16'hFFFF, 1'b1);
        step("small0", 16'd38, 16'd12, 1'b0);
        step("small1", 16'd111, 16'd121, 1'b1);
        step("ripple", 16'hFFFF, 16'h0001, 1'b1);
        step("msb", 16'h8000, 16'h8000, 1'b0);
        step("nocarry", 16'h5555, 16'hAAAA, 1'b1);
        step("mf0", 16'h1111, 16'h2222, 1'b1);
        step("mf1", 16'hF0F0, 16'h0F10, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", out, '0);
        q.delete();
        step("mf2_in_rst", 16'hABCD, 16'h1234, 1'b1);
        rst = 1'b0;
        step("post_rst", 16'd1234, 16'd4321, 1'b1);
        for (int n = 0; n < 1000; n++)
            step("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        for (int n = 0; n < LATENCY; n++) step("drain", '0, '0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
